// File: rtl/i2c_cmd_sequencer.sv
// Hardware command queue feeding an i2c_master: issues queued {cmd,data} words
// back-to-back, collects read bytes in an RX FIFO and halts on a write NACK.
module i2c_cmd_sequencer #(
    parameter int unsigned CMD_DEPTH = 16,
    parameter int unsigned RX_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_wr,
    input  logic [10:0]                  cmd_in,
    output logic                         cmd_full,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count,
    input  logic                         rx_rd,
    output logic [7:0]                   rx_data,
    output logic                         rx_empty,
    output logic [$clog2(RX_DEPTH):0]    rx_count,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic                         nack_err,
    output logic                         busy,
    output logic [2:0]                   i2c_cmd,
    output logic [7:0]                   i2c_din,
    output logic                         i2c_wr,
    input  logic                         i2c_ready,
    input  logic                         i2c_done,
    input  logic                         i2c_ack,
    input  logic [7:0]                   i2c_dout
);

    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam logic [CAW:0] CMD_FULL_CNT = CMD_DEPTH[CAW:0];
    localparam logic [RAW:0] RX_FULL_CNT  = RX_DEPTH[RAW:0];
    localparam logic [2:0]   CODE_WR      = 3'd1;
    localparam logic [2:0]   CODE_RD      = 3'd2;
    localparam logic [2:0]   CODE_LAST    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_GUARD, S_WAIT_RDY, S_WAIT_DATA, S_HALT
    } state_t;

    state_t         r_state;
    logic [2:0]     r_i2c_cmd;
    logic [7:0]     r_i2c_din;
    logic           r_i2c_wr;
    logic           r_nack;

    logic [10:0]    r_cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] r_cmd_wp, r_cmd_rp;
    logic [CAW:0]   r_cmd_cnt;
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RAW-1:0] r_rx_wp, r_rx_rp;
    logic [RAW:0]   r_rx_cnt;

    logic [10:0]    w_head;
    logic           w_cmd_push, w_cmd_pop, w_rx_push, w_rx_pop, w_rx_stall;

    assign w_head     = r_cmd_mem[r_cmd_rp];
    assign w_cmd_push = cmd_wr && !cmd_full && !flush;
    // At most one RD is ever in flight and it has landed before IDLE, so a full RX FIFO is the only stall case
    assign w_rx_stall = (w_head[10:8] == CODE_RD) && (r_rx_cnt == RX_FULL_CNT);
    assign w_cmd_pop  = (r_state == S_IDLE) && (r_cmd_cnt != '0) && i2c_ready && !r_nack && !w_rx_stall;
    assign w_rx_push  = (r_state == S_WAIT_DATA) && i2c_done && (r_i2c_cmd == CODE_RD);
    assign w_rx_pop   = rx_rd && (r_rx_cnt != '0);

    assign cmd_full  = (r_cmd_cnt == CMD_FULL_CNT);
    assign cmd_count = r_cmd_cnt;
    assign rx_empty  = (r_rx_cnt == '0);
    assign rx_count  = r_rx_cnt;
    assign rx_data   = rx_empty ? '0 : r_rx_mem[r_rx_rp];
    assign nack_err  = r_nack;
    assign busy      = (r_state != S_IDLE) || (r_cmd_cnt != '0);
    assign i2c_cmd   = r_i2c_cmd;
    assign i2c_din   = r_i2c_din;
    assign i2c_wr    = r_i2c_wr;

    always_ff @(posedge clk) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= cmd_in;
        if (w_rx_push)  r_rx_mem[r_rx_wp]   <= i2c_dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_cmd_cnt <= '0;
        end else if (flush) begin
            r_cmd_rp  <= r_cmd_wp;
            r_cmd_cnt <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CAW'(1);
            if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CAW'(1);
            r_cmd_cnt <= r_cmd_cnt + {{CAW{1'b0}}, w_cmd_push} - {{CAW{1'b0}}, w_cmd_pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + RAW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RAW'(1);
            r_rx_cnt <= r_rx_cnt + {{RAW{1'b0}}, w_rx_push} - {{RAW{1'b0}}, w_rx_pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_i2c_cmd <= '0;
            r_i2c_din <= '0;
            r_i2c_wr  <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_i2c_wr <= 1'b0;
            if (err_clr) r_nack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Invalid codes are consumed by the pop but never reach the master
                    if (w_cmd_pop && (w_head[10:8] <= CODE_LAST)) begin
                        r_i2c_cmd <= w_head[10:8];
                        r_i2c_din <= w_head[7:0];
                        r_i2c_wr  <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_GUARD;
                S_GUARD: begin
                    if ((r_i2c_cmd == CODE_WR) || (r_i2c_cmd == CODE_RD)) r_state <= S_WAIT_DATA;
                    else                                                  r_state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: if (i2c_ready) r_state <= S_IDLE;
                S_WAIT_DATA: begin
                    if (i2c_done) begin
                        if ((r_i2c_cmd == CODE_WR) && i2c_ack) begin
                            r_nack  <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_WAIT_RDY;
                        end
                    end
                end
                S_HALT: if (err_clr) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer with a behavioural i2c_master model;
// monitors compare every i2c_wr pulse and every RX pop against queued expectations.
module tb_i2c_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_wr;
    logic [10:0] cmd_in;
    logic        cmd_full;
    logic [4:0]  cmd_count;
    logic        rx_rd;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic [4:0]  rx_count;
    logic        flush;
    logic        err_clr;
    logic        nack_err;
    logic        busy;
    logic [2:0]  i2c_cmd;
    logic [7:0]  i2c_din;
    logic        i2c_wr;
    logic        i2c_ready;
    logic        i2c_done;
    logic        i2c_ack;
    logic [7:0]  i2c_dout;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [10:0] exp_q[$];
    logic [7:0]  rx_exp_q[$];
    logic [7:0]  rd_q[$];
    bit          hold_rdy   = 1'b0;
    bit          model_nack = 1'b0;

    i2c_cmd_sequencer #(.CMD_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .cmd_wr(cmd_wr), .cmd_in(cmd_in),
        .cmd_full(cmd_full), .cmd_count(cmd_count), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .flush(flush), .err_clr(err_clr), .nack_err(nack_err), .busy(busy),
        .i2c_cmd(i2c_cmd), .i2c_din(i2c_din), .i2c_wr(i2c_wr),
        .i2c_ready(i2c_ready), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .i2c_dout(i2c_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // i2c_master model: reacts 2ns after the edge on which i2c_wr is visible
    initial begin : master_model
        logic [2:0] c;
        i2c_ready = 1'b1;
        i2c_done  = 1'b0;
        i2c_ack   = 1'b0;
        i2c_dout  = 8'h00;
        forever begin
            @(posedge clk); #2;
            i2c_done = 1'b0;
            if (reset && i2c_wr) begin
                c = i2c_cmd;
                i2c_ready = 1'b0;
                repeat (3) begin @(posedge clk); #2; end
                if (c == 3'd1 || c == 3'd2) begin
                    i2c_ack  = (c == 3'd1) ? model_nack : 1'b0;
                    i2c_dout = (c == 3'd2 && rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
                    i2c_done = 1'b1;
                    @(posedge clk); #2;
                    i2c_done = 1'b0;
                end
                @(posedge clk); #2;
            end
            i2c_ready = !hold_rdy;
        end
    end

    initial begin : monitor
        logic        prev_rdy;
        logic        prev_wr;
        logic [10:0] e;
        logic [7:0]  eb;
        prev_rdy = 1'b1;
        prev_wr  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && i2c_wr) begin
                check("wr_after_ready", {31'd0, prev_rdy}, 32'd1);
                check("wr_single_pulse", {31'd0, prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_wr: got cmd=%0d din=%02h required no issue", i2c_cmd, i2c_din);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_word", {21'd0, i2c_cmd, i2c_din}, {21'd0, e});
                end
            end
            if (reset && rx_rd && !rx_empty) begin
                if (rx_exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rx_pop: got %02h required no data", rx_data);
                end else begin
                    eb = rx_exp_q.pop_front();
                    check("rx_byte", {24'd0, rx_data}, {24'd0, eb});
                end
            end
            prev_rdy = i2c_ready;
            prev_wr  = i2c_wr;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [10:0] w, input bit issued);
        if (issued) exp_q.push_back(w);
        cmd_wr = 1'b1;
        cmd_in = w;
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(busy == 1'b0 && i2c_ready == 1'b1 && exp_q.size() == 0) && n < 1000) begin
            tick();
            n++;
        end
        check(nm, {31'd0, n < 1000}, 32'd1);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_cmd_full"},  {31'd0, cmd_full}, 32'd0);
        check({p, "_cmd_count"}, {27'd0, cmd_count}, 32'd0);
        check({p, "_rx_empty"},  {31'd0, rx_empty}, 32'd1);
        check({p, "_rx_count"},  {27'd0, rx_count}, 32'd0);
        check({p, "_rx_data"},   {24'd0, rx_data}, 32'd0);
        check({p, "_nack_err"},  {31'd0, nack_err}, 32'd0);
        check({p, "_busy"},      {31'd0, busy}, 32'd0);
        check({p, "_i2c_cmd"},   {29'd0, i2c_cmd}, 32'd0);
        check({p, "_i2c_din"},   {24'd0, i2c_din}, 32'd0);
        check({p, "_i2c_wr"},    {31'd0, i2c_wr}, 32'd0);
    endtask

    initial begin : stimulus
        int n;
        reset = 1'b0; cmd_wr = 1'b0; cmd_in = '0; rx_rd = 1'b0;
        flush = 1'b0; err_clr = 1'b0;
        tick(3);
        check_reset_vals("rst");
        reset = 1'b1;
        tick(2);

        // 1: START, WR A0, WR 10, STOP with latency check on the first issue
        push({3'd0, 8'h00}, 1'b1);
        check("lat_wr_n1", {31'd0, i2c_wr}, 32'd0);
        check("t1_cmd_count", {27'd0, cmd_count}, 32'd1);
        push({3'd1, 8'hA0}, 1'b1);
        check("lat_wr_n2", {31'd0, i2c_wr}, 32'd1);
        push({3'd1, 8'h10}, 1'b1);
        push({3'd3, 8'h00}, 1'b1);
        check("t1_busy_mid", {31'd0, busy}, 32'd1);
        wait_idle("t1_idle");
        check("t1_nack", {31'd0, nack_err}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2: two reads into RX FIFO, drained in order, then an ignored read on empty
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'hC3);
        push({3'd0, 8'h00}, 1'b1);
        push({3'd1, 8'hA1}, 1'b1);
        push({3'd2, 8'h00}, 1'b1);
        push({3'd2, 8'h01}, 1'b1);
        push({3'd3, 8'h00}, 1'b1);
        wait_idle("t2_idle");
        check("t2_rx_count", {27'd0, rx_count}, 32'd2);
        check("t2_rx_data", {24'd0, rx_data}, 32'h5A);
        check("t2_rx_empty0", {31'd0, rx_empty}, 32'd0);
        rx_exp_q.push_back(8'h5A);
        rx_exp_q.push_back(8'hC3);
        rx_rd = 1'b1;
        tick();
        check("t2_rx_data2", {24'd0, rx_data}, 32'hC3);
        tick();
        rx_rd = 1'b0;
        check("t2_rx_empty1", {31'd0, rx_empty}, 32'd1);
        check("t2_rx_data0", {24'd0, rx_data}, 32'd0);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        check("t2_rx_rd_empty", {27'd0, rx_count}, 32'd0);

        // 3: NACK halts with STOP left queued; flush, requeue STOP, clear error
        model_nack = 1'b1;
        push({3'd1, 8'h3C}, 1'b1);
        push({3'd3, 8'h00}, 1'b0);
        n = 0;
        while (!nack_err && n < 200) begin tick(); n++; end
        check("t3_nack_set", {31'd0, nack_err}, 32'd1);
        model_nack = 1'b0;
        tick(10);
        check("t3_stop_held", {27'd0, cmd_count}, 32'd1);
        check("t3_busy_halt", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flushed", {27'd0, cmd_count}, 32'd0);
        push({3'd3, 8'h00}, 1'b1);
        tick(3);
        check("t3_no_issue_halt", {27'd0, cmd_count}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_nack_clr", {31'd0, nack_err}, 32'd0);
        wait_idle("t3_idle");

        // 4: fill with ready held low, overflow push dropped, flush beats cmd_wr
        hold_rdy = 1'b1;
        tick(3);
        for (int i = 0; i < 16; i++) push({3'd0, 8'(i)}, 1'b0);
        check("t4_full", {31'd0, cmd_full}, 32'd1);
        check("t4_count16", {27'd0, cmd_count}, 32'd16);
        push({3'd0, 8'hFF}, 1'b0);
        check("t4_overflow", {27'd0, cmd_count}, 32'd16);
        flush = 1'b1; cmd_wr = 1'b1; cmd_in = {3'd0, 8'h11};
        tick();
        flush = 1'b0; cmd_wr = 1'b0;
        check("t4_flush_full", {27'd0, cmd_count}, 32'd0);
        check("t4_not_full", {31'd0, cmd_full}, 32'd0);
        flush = 1'b1; cmd_wr = 1'b1; cmd_in = {3'd0, 8'h22};
        tick();
        flush = 1'b0; cmd_wr = 1'b0;
        check("t4_flush_beats_wr", {27'd0, cmd_count}, 32'd0);
        hold_rdy = 1'b0;
        tick(10);
        check("t4_busy", {31'd0, busy}, 32'd0);

        // 5: RX fill stalls the next RD until a byte is popped; code 6 is discarded
        for (int i = 1; i <= 16; i++) rd_q.push_back(8'(i));
        rd_q.push_back(8'h77);
        for (int i = 0; i < 16; i++) push({3'd2, 7'd0, 1'(i)}, 1'b1);
        wait_idle("t5_fill_idle");
        check("t5_rx_full", {27'd0, rx_count}, 32'd16);
        push({3'd2, 8'h01}, 1'b1);
        tick(10);
        check("t5_rd_stalled", {27'd0, cmd_count}, 32'd1);
        check("t5_busy_stall", {31'd0, busy}, 32'd1);
        rx_exp_q.push_back(8'h01);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        wait_idle("t5_rd_idle");
        check("t5_rx_refull", {27'd0, rx_count}, 32'd16);
        push({3'd6, 8'h55}, 1'b0);
        tick(5);
        check("t5_code6_popped", {27'd0, cmd_count}, 32'd0);
        check("t5_code6_idle", {31'd0, busy}, 32'd0);

        // 6: reset while waiting for write data
        push({3'd1, 8'h55}, 1'b1);
        n = 0;
        while (!i2c_wr && n < 50) begin tick(); n++; end
        check("t6_issued", {31'd0, i2c_wr}, 32'd1);
        tick(2);
        check("t6_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("t6");
        tick(3);
        reset = 1'b1;
        tick(20);
        check("t6_no_resume", {31'd0, busy}, 32'd0);
        check("t6_no_rx", {27'd0, rx_count}, 32'd0);
        check("t6_sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
